adder: RTL and testbench



---
 rtl/adder.sv | 53 +++++
 tb/tb_adder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/adder.sv
// Parameterised ripple-carry adder: a chain of mux-based full-adder cells with an immediate
// result plus a one-cycle registered copy carrying a signed-overflow flag and a valid strobe.
module adder #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             en,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic [WIDTH-1:0] res_q,
    output logic             carry_q,
    output logic             ovf_q,
    output logic             valid_q
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_p;
    logic             w_ovf;

    assign w_c[0] = cin;

    // Each cell: sum picks propagate or its complement on the incoming carry; carry-out picks
    // the incoming carry when propagating, otherwise a_i (equal to b_i, i.e. generate/kill).
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign w_p[i]     = a[i] ^ b[i];
        assign res[i]     = w_c[i] ? ~w_p[i] : w_p[i];
        assign w_c[i + 1] = w_p[i] ? w_c[i] : a[i];
    end

    assign carry = w_c[WIDTH];
    assign w_ovf = w_c[WIDTH-1] ^ w_c[WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (en) begin
            res_q   <= res;
            carry_q <= carry;
            ovf_q   <= w_ovf;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder at WIDTH 1, 4 and 8: directed corner vectors plus a randomised
// WIDTH=8 run scored against an arithmetic reference model.
module tb_adder;

    logic clk;
    logic rst_n;
    logic en;

    logic       a1, b1, cin1, res1, carry1, res1_q, carry1_q, ovf1_q, valid1_q;
    logic [3:0] a4, b4, res4, res4_q;
    logic       cin4, carry4, carry4_q, ovf4_q, valid4_q;
    logic [7:0] a8, b8, res8, res8_q;
    logic       cin8, carry8, carry8_q, ovf8_q, valid8_q;

    int n_cmp;
    int n_bad;

    adder #(.WIDTH(1)) u_add1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .en(en),
        .res(res1), .carry(carry1), .res_q(res1_q), .carry_q(carry1_q),
        .ovf_q(ovf1_q), .valid_q(valid1_q)
    );

    adder #(.WIDTH(4)) u_add4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .en(en),
        .res(res4), .carry(carry4), .res_q(res4_q), .carry_q(carry4_q),
        .ovf_q(ovf4_q), .valid_q(valid4_q)
    );

    adder #(.WIDTH(8)) u_add8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .en(en),
        .res(res8), .carry(carry8), .res_q(res8_q), .carry_q(carry8_q),
        .ovf_q(ovf8_q), .valid_q(valid8_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full sum a+b+cin as a plain integer; bit w is the carry.
    function automatic int ref_sum(input int a, input int b, input int cin);
        return a + b + cin;
    endfunction

    // Signed overflow: the true signed sum does not fit in w bits.
    function automatic bit ref_ovf(input int w, input int a, input int b, input int cin);
        int sa, sb, s;
        sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        s  = sa + sb + cin;
        return (s < -(1 << (w - 1))) || (s > (1 << (w - 1)) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int s;
    int e_res, e_carry, e_ovf, e_valid;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        {a1, b1, cin1} = '0;
        {a4, b4, cin4} = '0;
        {a8, b8, cin8} = '0;

        // Reset state.
        tick();
        check_eq("rst_res4_q", 32'(res4_q), 0);
        check_eq("rst_carry4_q", 32'(carry4_q), 0);
        check_eq("rst_ovf4_q", 32'(ovf4_q), 0);
        check_eq("rst_valid4_q", 32'(valid4_q), 0);
        check_eq("rst_valid8_q", 32'(valid8_q), 0);
        check_eq("rst_valid1_q", 32'(valid1_q), 0);

        // WIDTH=1 exhaustive, both carry-ins, combinational only.
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 4; i++) begin
                a1 = 1'(i >> 1); b1 = 1'(i & 1); cin1 = 1'(c);
                #1;
                s = ref_sum(int'(a1), int'(b1), c);
                check_eq("w1_res", 32'(res1), 32'(s & 1));
                check_eq("w1_carry", 32'(carry1), 32'((s >> 1) & 1));
            end
        end

        // Reset priority over en: registers stay clear, combinational path unaffected.
        rst_n = 1'b0; en = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b0;
        #1;
        check_eq("prio_res4", 32'(res4), 32'hE);
        check_eq("prio_carry4", 32'(carry4), 1);
        tick();
        check_eq("prio_res4_q", 32'(res4_q), 0);
        check_eq("prio_carry4_q", 32'(carry4_q), 0);
        check_eq("prio_valid4_q", 32'(valid4_q), 0);

        // Capture 3+5, then hold with en low.
        rst_n = 1'b1; en = 1'b1; a4 = 4'd3; b4 = 4'd5;
        tick();
        check_eq("cap_res4_q", 32'(res4_q), 8);
        check_eq("cap_carry4_q", 32'(carry4_q), 0);
        check_eq("cap_ovf4_q", 32'(ovf4_q), 1);
        check_eq("cap_valid4_q", 32'(valid4_q), 1);
        en = 1'b0; a4 = 4'd1; b4 = 4'd1;
        tick();
        check_eq("hold_res4_q", 32'(res4_q), 8);
        check_eq("hold_ovf4_q", 32'(ovf4_q), 1);
        check_eq("hold_valid4_q", 32'(valid4_q), 0);

        // WIDTH=4 corner vectors including all-ones wrap with carry-in.
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0; end
                1: begin a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; end
                2: begin a4 = 4'h8; b4 = 4'h8; cin4 = 1'b0; end
                default: begin a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; end
            endcase
            #1;
            s = ref_sum(int'(a4), int'(b4), int'(cin4));
            check_eq("w4_res", 32'(res4), 32'(s & 'hF));
            check_eq("w4_carry", 32'(carry4), 32'((s >> 4) & 1));
            e_ovf = int'(ref_ovf(4, int'(a4), int'(b4), int'(cin4)));
            tick();
            check_eq("w4_res_q", 32'(res4_q), 32'(s & 'hF));
            check_eq("w4_carry_q", 32'(carry4_q), 32'((s >> 4) & 1));
            check_eq("w4_ovf_q", 32'(ovf4_q), 32'(e_ovf));
            check_eq("w4_valid_q", 32'(valid4_q), 1);
        end

        // WIDTH=1 overflow follows cin ^ carry.
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b1;
        tick();
        check_eq("w1_ovf_q", 32'(ovf1_q), 32'(ref_ovf(1, 0, 0, 1)));

        // Randomised WIDTH=8 run with occasional reset and en gaps.
        rst_n = 1'b0;
        tick();
        e_res = 0; e_carry = 0; e_ovf = 0; e_valid = 0;
        for (int i = 0; i < 1000; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            en    = ($urandom_range(0, 3) != 0);
            a8    = 8'($urandom);
            b8    = 8'($urandom);
            cin8  = 1'($urandom);
            #1;
            s = ref_sum(int'(a8), int'(b8), int'(cin8));
            check_eq("r8_res", 32'(res8), 32'(s & 'hFF));
            check_eq("r8_carry", 32'(carry8), 32'((s >> 8) & 1));
            if (!rst_n) begin
                e_res = 0; e_carry = 0; e_ovf = 0; e_valid = 0;
            end else if (en) begin
                e_res   = s & 'hFF;
                e_carry = (s >> 8) & 1;
                e_ovf   = int'(ref_ovf(8, int'(a8), int'(b8), int'(cin8)));
                e_valid = 1;
            end else begin
                e_valid = 0;
            end
            tick();
            check_eq("r8_res_q", 32'(res8_q), 32'(e_res));
            check_eq("r8_carry_q", 32'(carry8_q), 32'(e_carry));
            check_eq("r8_ovf_q", 32'(ovf8_q), 32'(e_ovf));
            check_eq("r8_valid_q", 32'(valid8_q), 32'(e_valid));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
